rs_syndrome_calc_par: RTL and testbench



---
 rtl/rs_syndrome_calc_par.sv | 108 ++++++++++
 tb/tb_rs_syndrome_calc_par.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/rs_syndrome_calc_par.sv
// rs_syndrome_calc_par: P-parallel RS(544,522) GF(2^10) syndrome calculator, double-buffered ahead of the riBM solver
module rs_syndrome_calc_par #(
  parameter int N  = 544,
  parameter int T  = 11,
  parameter int W  = 10,
  parameter int P  = 4,
  parameter int CW = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] sym_i [P],
  input  logic         sym_valid_i,
  input  logic         sym_sop_i,
  output logic         sym_ready_o,
  input  logic         solver_busy_i,
  output logic [W-1:0] syn_o [2*T+1],
  output logic         syn_valid_o,
  output logic         start_o,
  output logic         err_free_o,
  output logic         abort_o
);
  localparam int NB = N / P;
  localparam logic [CW-1:0] LAST = CW'(NB - 1);
  localparam logic [W-1:0] POLY = W'(9);
  if (N % P != 0 || NB - 1 >= 2 ** CW) begin : g_bad_param
    $error("rs_syndrome_calc_par: N must be a multiple of P and N/P-1 must fit in CW bits");
  end
  function automatic logic [W-1:0] gf_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r;
    r = '0;
    for (int i = W - 1; i >= 0; i--) r = {r[W-2:0], 1'b0} ^ (r[W-1] ? POLY : '0) ^ (b[i] ? a : '0);
    return r;
  endfunction
  function automatic logic [W-1:0] gf_pow(input int e);
    logic [W-1:0] r;
    r = W'(1);
    for (int i = 0; i < e; i++) r = gf_mul(r, W'(2));
    return r;
  endfunction
  logic [W-1:0] acc_q [2*T];
  logic [W-1:0] acc_d [2*T];
  logic [W-1:0] syn_q [2*T];
  logic [CW-1:0] beat_cnt_q, beat_cnt_d;
  logic in_frame_q, in_frame_d, pending_q, pending_d, acc_full_q, acc_full_d;
  logic err_free_q, abort_q, abort_d, any_nz;
  logic accept, take, complete, load;
  assign accept   = sym_valid_i && sym_ready_o;
  assign take     = accept && (sym_sop_i || in_frame_q);
  assign complete = accept && !sym_sop_i && in_frame_q && beat_cnt_q == LAST;
  assign start_o  = pending_q && !solver_busy_i;
  // A finished result takes the output buffer if it is free or being vacated this cycle
  assign load     = (complete && (!pending_q || start_o)) || (acc_full_q && !pending_q);
  for (genvar j = 1; j <= 2 * T; j++) begin : g_syn
    localparam logic [W-1:0] AP = gf_pow(j * P);
    logic [W-1:0] term [P];
    logic [W-1:0] sum;
    for (genvar k = 0; k < P; k++) begin : g_term
      localparam logic [W-1:0] AK = gf_pow(j * (P - 1 - k));
      assign term[k] = gf_mul(sym_i[k], AK);
    end
    always_comb begin
      sum = '0;
      for (int k = 0; k < P; k++) sum ^= term[k];
    end
    assign acc_d[j-1] = take ? ((sym_sop_i ? '0 : gf_mul(acc_q[j-1], AP)) ^ sum) : acc_q[j-1];
    assign syn_o[j] = syn_q[j-1];
  end
  assign syn_o[0] = '0;
  always_comb begin
    any_nz = 1'b0;
    for (int j = 0; j < 2 * T; j++) any_nz |= |acc_d[j];
  end
  always_comb begin
    in_frame_d = (accept && sym_sop_i) ? 1'b1 : complete ? 1'b0 : in_frame_q;
    beat_cnt_d = (accept && sym_sop_i) ? CW'(1) : complete ? '0 :
                 (accept && in_frame_q) ? beat_cnt_q + CW'(1) : beat_cnt_q;
    abort_d    = accept && sym_sop_i && in_frame_q && beat_cnt_q != '0;
    pending_d  = load ? 1'b1 : start_o ? 1'b0 : pending_q;
    acc_full_d = (complete && pending_q && !start_o) ? 1'b1 : (acc_full_q && !pending_q) ? 1'b0 : acc_full_q;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q      <= '{default: '0};
      syn_q      <= '{default: '0};
      beat_cnt_q <= '0;
      in_frame_q <= 1'b0;
      pending_q  <= 1'b0;
      acc_full_q <= 1'b0;
      err_free_q <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      beat_cnt_q <= beat_cnt_d;
      in_frame_q <= in_frame_d;
      pending_q  <= pending_d;
      acc_full_q <= acc_full_d;
      abort_q    <= abort_d;
      if (load) begin
        syn_q      <= acc_d;
        err_free_q <= !any_nz;
      end
    end
  end
  assign sym_ready_o = !acc_full_q;
  assign syn_valid_o = pending_q;
  assign err_free_o  = err_free_q;
  assign abort_o     = abort_q;
endmodule

// File: tb/tb_rs_syndrome_calc_par.sv
// tb_rs_syndrome_calc_par: directed bench for rs_syndrome_calc_par with a serial Horner reference
module tb_rs_syndrome_calc_par;
  localparam int N = 544, T = 11, W = 10, P = 4, CW = 8, NB = N / P, S = 2 * T;
  logic clk = 1'b0, rst;
  logic [W-1:0] sym [P];
  logic sym_valid, sym_sop, sym_ready, busy;
  logic [W-1:0] syn [2*T+1];
  logic syn_valid, start, err_free, abort;
  int checks = 0, failures = 0, abort_cnt = 0, a0;
  logic [W-1:0] cw [N];
  logic [W-1:0] g [S+1];
  logic [S*W-1:0] exp_a, exp_b;
  always #5 clk = ~clk;
  always @(posedge clk) if (abort === 1'b1) abort_cnt++;
  rs_syndrome_calc_par #(.N(N), .T(T), .W(W), .P(P), .CW(CW)) dut (
    .clk_i(clk), .rst_i(rst), .sym_i(sym), .sym_valid_i(sym_valid), .sym_sop_i(sym_sop),
    .sym_ready_o(sym_ready), .solver_busy_i(busy), .syn_o(syn), .syn_valid_o(syn_valid),
    .start_o(start), .err_free_o(err_free), .abort_o(abort));
  function automatic logic [W-1:0] gmul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r, x;
    r = '0;
    x = a;
    for (int i = 0; i < W; i++) begin
      if (b[i]) r ^= x;
      x = x[W-1] ? ({x[W-2:0], 1'b0} ^ 10'h009) : {x[W-2:0], 1'b0};
    end
    return r;
  endfunction
  function automatic logic [W-1:0] gpow(input int e);
    logic [W-1:0] r;
    r = 10'h001;
    for (int i = 0; i < e; i++) r = gmul(r, 10'h002);
    return r;
  endfunction
  function automatic logic [S*W-1:0] model();
    logic [S*W-1:0] v;
    logic [W-1:0] a, s;
    for (int j = 1; j <= S; j++) begin
      a = gpow(j);
      s = '0;
      for (int i = N - 1; i >= 0; i--) s = gmul(s, a) ^ cw[i];
      v[(j-1)*W +: W] = s;
    end
    return v;
  endfunction
  function automatic logic [S*W-1:0] obs();
    logic [S*W-1:0] v;
    for (int j = 1; j <= S; j++) v[(j-1)*W +: W] = syn[j];
    return v;
  endfunction
  task automatic chk(input string tag, input logic [255:0] o, input logic [255:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask
  task automatic send_beats(input int first, input int last);
    for (int b = first; b <= last; b++) begin
      @(negedge clk);
      sym_valid = 1'b1;
      sym_sop = (b == 0);
      for (int k = 0; k < P; k++) sym[k] = cw[N-1-(b*P+k)];
    end
  endtask
  task automatic idle();
    @(negedge clk);
    sym_valid = 1'b0;
    sym_sop = 1'b0;
  endtask
  task automatic clear_cw();
    for (int i = 0; i < N; i++) cw[i] = '0;
  endtask
  task automatic add_errors();
    int pos [11] = '{543, 500, 400, 321, 250, 137, 100, 64, 22, 5, 0};
    for (int i = 0; i < 11; i++) cw[pos[i]] ^= W'(37 * i + 11);
  endtask
  initial begin
    rst = 1'b1;
    sym_valid = 1'b0;
    sym_sop = 1'b0;
    busy = 1'b0;
    for (int k = 0; k < P; k++) sym[k] = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", sym_ready, 1);
    chk("rst_valid", syn_valid, 0);
    chk("rst_start", start, 0);
    chk("rst_abort", abort, 0);
    chk("rst_errfree", err_free, 0);
    chk("rst_syn", obs(), 0);
    rst = 1'b0;
    clear_cw();
    send_beats(0, NB - 1);
    idle();
    chk("zero_valid", syn_valid, 1);
    chk("zero_start", start, 1);
    chk("zero_syn", obs(), 0);
    chk("zero_errfree", err_free, 1);
    idle();
    chk("zero_start_once", start, 0);
    chk("zero_consumed", syn_valid, 0);
    cw[0] = 10'h001;
    send_beats(0, NB - 1);
    idle();
    chk("r0_syn", obs(), {S{10'h001}});
    chk("r0_errfree", err_free, 0);
    clear_cw();
    cw[1] = 10'h001;
    send_beats(0, NB - 1);
    idle();
    chk("r1_s1", syn[1], 10'h002);
    chk("r1_s10", syn[10], 10'h009);
    chk("r1_s11", syn[11], 10'h012);
    chk("r1_syn", obs(), model());
    chk("r1_syn0", syn[0], 0);
    clear_cw();
    for (int i = 0; i <= S; i++) g[i] = (i == 0) ? 10'h001 : 10'h000;
    for (int j = 1; j <= S; j++) begin
      for (int i = S; i >= 1; i--) g[i] = g[i-1] ^ gmul(g[i], gpow(j));
      g[0] = gmul(g[0], gpow(j));
    end
    for (int i = 0; i <= S; i++) begin
      cw[i] ^= gmul(g[i], 10'h155);
      cw[i+200] ^= gmul(g[i], 10'h2a3);
      cw[i+521] ^= gmul(g[i], 10'h001);
    end
    send_beats(0, NB - 1);
    idle();
    chk("cw_syn", obs(), 0);
    chk("cw_errfree", err_free, 1);
    add_errors();
    exp_a = model();
    send_beats(0, NB - 1);
    idle();
    chk("err_syn", obs(), exp_a);
    chk("err_errfree", err_free, 0);
    idle();
    busy = 1'b1;
    send_beats(0, NB - 1);
    cw[7] ^= 10'h3ff;
    exp_b = model();
    send_beats(0, NB - 1);
    idle();
    chk("b2b_ready_low", sym_ready, 0);
    chk("b2b_pending", syn_valid, 1);
    chk("b2b_syn_first", obs(), exp_a);
    chk("b2b_no_start", start, 0);
    busy = 1'b0;
    #1;
    chk("b2b_start1", start, 1);
    @(negedge clk);
    chk("b2b_gap_valid", syn_valid, 0);
    chk("b2b_gap_start", start, 0);
    chk("b2b_gap_ready", sym_ready, 0);
    @(negedge clk);
    chk("b2b_second_valid", syn_valid, 1);
    chk("b2b_syn_second", obs(), exp_b);
    chk("b2b_start2", start, 1);
    chk("b2b_ready_back", sym_ready, 1);
    @(negedge clk);
    chk("b2b_done", syn_valid, 0);
    busy = 1'b1;
    send_beats(0, NB - 1);
    cw[300] ^= 10'h0a5;
    exp_b = model();
    send_beats(0, NB - 2);
    send_beats(NB - 1, NB - 1);
    busy = 1'b0;
    idle();
    chk("simul_valid", syn_valid, 1);
    chk("simul_syn", obs(), exp_b);
    chk("simul_ready", sym_ready, 1);
    chk("simul_start", start, 1);
    idle();
    a0 = abort_cnt;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      sym_valid = 1'b1;
      sym_sop = 1'b0;
      for (int k = 0; k < P; k++) sym[k] = W'($urandom);
    end
    idle();
    chk("idle_ignored", syn_valid, 0);
    send_beats(0, 49);
    clear_cw();
    cw[3] = 10'h111;
    cw[543] = 10'h2c3;
    exp_b = model();
    send_beats(0, NB - 1);
    idle();
    chk("abort_once", abort_cnt - a0, 1);
    chk("abort_syn_new", obs(), exp_b);
    idle();
    send_beats(0, 69);
    @(negedge clk);
    rst = 1'b1;
    sym_valid = 1'b0;
    sym_sop = 1'b0;
    @(negedge clk);
    chk("rst_mid_valid", syn_valid, 0);
    chk("rst_mid_syn", obs(), 0);
    chk("rst_mid_ready", sym_ready, 1);
    rst = 1'b0;
    busy = 1'b1;
    send_beats(0, NB - 1);
    idle();
    chk("rst_pend_before", syn_valid, 1);
    rst = 1'b1;
    busy = 1'b0;
    @(negedge clk);
    chk("rst_pend_valid", syn_valid, 0);
    chk("rst_pend_start", start, 0);
    chk("rst_pend_errfree", err_free, 0);
    chk("rst_pend_syn", obs(), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_pend_no_start", start, 0);
    clear_cw();
    add_errors();
    exp_a = model();
    send_beats(0, NB - 1);
    idle();
    chk("post_rst_syn", obs(), exp_a);
    chk("post_rst_start", start, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
